twf_gen_stream: RTL
===================

// Module: twf_gen_stream
// PURPOSE
//  Streaming twiddle-factor generator for the radix-2^k FFT stages; emits complex pairs (twf_re, twf_im) in signed
//  2.7 format, one per accepted beat, for a whole frame. Replaces per-stage imag-only case ROMs: one quarter-wave
//  cosine ROM plus quadrant folding, selectable forward/inverse sign, ready/valid backpressure. Feeds stage multipliers.
// PARAMETERS
//  INDEX_WIDTH  512  frame length in beats (multiple of N_POINT); IDX_W = $clog2(INDEX_WIDTH)
//  GRP_BITS     3    index bits selecting twiddle group, index[GRP_BITS+POS_BITS-1:POS_BITS]
//  POS_BITS     3    index bits selecting position in group, index[POS_BITS-1:0]
//  BIT_WIDTH    9    output width, signed 2.7 (FRAC_BITS=7; +1.0 = 128)
//  N_POINT      2**(GRP_BITS+POS_BITS) = 64  twiddle period; supported 16, 64, 256
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rstn       in   1          asynchronous active-low reset
//  start      in   1          frame start pulse; honoured only when busy==0
//  inverse    in   1          0: W=exp(-j*theta) (FFT), 1: exp(+j*theta) (IFFT); sampled with start
//  out_ready  in   1          downstream accepts current beat
//  out_valid  out  1          twf_re/twf_im/out_index valid
//  out_index  out  IDX_W      frame index of current beat
//  twf_re     out  BIT_WIDTH  round(128*cos(theta))
//  twf_im     out  BIT_WIDTH  -/+round(128*sin(theta)) (forward/inverse)
//  out_last   out  1          high with beat INDEX_WIDTH-1
//  busy       out  1          frame in progress (start accepted .. last beat accepted)
// BEHAVIOUR
//  Reset: all outputs, counter, pipeline valids and inverse flag = 0, immediately (async), released on clk.
//  Exponent: e = (bitrev_GRP(grp) * pos) mod N_POINT; theta = 2*pi*e/N_POINT. Index bits above GRP+POS ignored.
//  Fold: q = e[top 2 bits], r = e mod N/4, C[k]=round(128*cos(2*pi*k/N)), k=0..N/4, S[r]=C[N/4-r]:
//   q0: cos=C[r],  sin=S[r];  q1: cos=-S[r], sin=C[r];  q2: cos=-C[r], sin=-S[r];  q3: cos=S[r], sin=-C[r].
//  Width: ROM entries unsigned 8 bit (0..128); negate after sign-extend to BIT_WIDTH; no saturation needed.
//  Pipeline enable en = !out_valid | out_ready; when en=0 every stage, counter and outputs hold (stable).
//   S0 counter: start&!busy -> idx=0, v0=1, busy=1, latch inverse; else if en&v0: idx++; idx==INDEX_WIDTH-1 -> v0=0.
//   S1: register q, r, both ROM addresses, index, last, valid.
//   S2: register ROM data with quadrant/inverse sign -> outputs.
//  Latency: first out_valid rises after 3rd clk edge counting the edge sampling start; then 1 beat/clk if ready.
//  Frame end: busy drops the cycle after beat with out_last is accepted; out_valid then 0 until next start.
//  start while busy=1: ignored (no restart, inverse unchanged). start same cycle as last accept: ignored.
//  Reset mid-frame: frame abandoned, no further beats; next start restarts at index 0.
//  No beat dropped or duplicated under any out_ready pattern; exactly INDEX_WIDTH beats per frame.
// STRUCTURE
//  twf_pkg: twf_t (logic signed [BIT_WIDTH-1:0]), FRAC_BITS, quadrant enum {Q0..Q3}, function bitrev(grp).
//  Sub-module twf_qrom: combinational dual-read quarter-wave cosine case table (N/4+1 entries), script-generated
//  per supported N_POINT; twf_gen_stream instantiates one, registers its outputs in S2.
// TESTING
//  1 Reset, no start -> out_valid=0, busy=0, twf_re=twf_im=0, out_index=0.
//  2 start, inverse=0, out_ready=1 -> 512 consecutive beats, out_index 0..511, out_last only on 511, busy falls after.
//  3 Forward values: idx 9 -> (118,-49); idx 12 -> (0,-128); idx 31 -> (-71,106); idx 63 -> (13,127); idx 72 -> (128,0).
//  4 inverse=1 -> idx 9 -> (118,49); idx 12 -> (0,128); re identical to forward for all 512 beats.
//  5 out_ready low 5 cycles at idx 20, random toggling elsewhere -> outputs stable while stalled, beats match scoreboard.
//  6 rstn low at idx 200 -> outputs 0 immediately; start pulse during busy ignored; new start -> index 0, 3-edge latency.

Source files
------------

// File: rtl/twf_pkg.sv
// Shared types and helpers for the streaming twiddle-factor generator.
package twf_pkg;

    localparam int TWF_BITS  = 9;
    localparam int FRAC_BITS = 7;
    localparam int ROM_BITS  = 8;

    typedef logic signed [TWF_BITS-1:0] twf_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quad_t;

    // Reverse the low nbits of grp; bits above nbits come back as zero.
    function automatic logic [7:0] bitrev(input logic [7:0] grp, input int nbits);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) r[i] = grp[nbits-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/twf_qrom.sv
// Quarter-wave cosine table C[k] = round(128*cos(2*pi*k/N)), k = 0..N/4, two read ports.
// Latency: combinational.
// Backpressure: none, pure lookup.
module twf_qrom
    import twf_pkg::*;
#(
    parameter int N_POINT = 64,
    parameter int AW      = 5
) (
    input  logic [AW-1:0]       addr_a,
    input  logic [AW-1:0]       addr_b,
    output logic [ROM_BITS-1:0] data_a,
    output logic [ROM_BITS-1:0] data_b
);

    generate
        if (N_POINT == 16) begin : g_n16
            localparam logic [7:0] C16 [0:4] = '{8'd128, 8'd118, 8'd91, 8'd49, 8'd0};
            assign data_a = C16[addr_a];
            assign data_b = C16[addr_b];
        end else if (N_POINT == 64) begin : g_n64
            localparam logic [7:0] C64 [0:16] = '{
                8'd128, 8'd127, 8'd126, 8'd122, 8'd118, 8'd113, 8'd106, 8'd99,
                8'd91,  8'd81,  8'd71,  8'd60,  8'd49,  8'd37,  8'd25,  8'd13,
                8'd0
            };
            assign data_a = C64[addr_a];
            assign data_b = C64[addr_b];
        end else begin : g_n256
            localparam logic [7:0] C256 [0:64] = '{
                8'd128, 8'd128, 8'd128, 8'd128, 8'd127, 8'd127, 8'd127, 8'd126,
                8'd126, 8'd125, 8'd124, 8'd123, 8'd122, 8'd122, 8'd121, 8'd119,
                8'd118, 8'd117, 8'd116, 8'd114, 8'd113, 8'd111, 8'd110, 8'd108,
                8'd106, 8'd105, 8'd103, 8'd101, 8'd99,  8'd97,  8'd95,  8'd93,
                8'd91,  8'd88,  8'd86,  8'd84,  8'd81,  8'd79,  8'd76,  8'd74,
                8'd71,  8'd68,  8'd66,  8'd63,  8'd60,  8'd58,  8'd55,  8'd52,
                8'd49,  8'd46,  8'd43,  8'd40,  8'd37,  8'd34,  8'd31,  8'd28,
                8'd25,  8'd22,  8'd19,  8'd16,  8'd13,  8'd9,   8'd6,   8'd3,
                8'd0
            };
            assign data_a = C256[addr_a];
            assign data_b = C256[addr_b];
        end
    endgenerate

endmodule

// File: rtl/twf_gen_stream.sv
// Streams one frame of complex twiddles (signed 2.7) from a quarter-wave ROM with quadrant folding.
// Latency: first beat valid 3 clocks after the edge that samples start, then one beat per clock.
// Backpressure: out_ready low freezes counter, pipeline and outputs; no beat is lost or repeated.
module twf_gen_stream
    import twf_pkg::*;
#(
    parameter int INDEX_WIDTH = 512,
    parameter int GRP_BITS    = 3,
    parameter int POS_BITS    = 3,
    parameter int BIT_WIDTH   = 9,
    localparam int N_POINT    = 2 ** (GRP_BITS + POS_BITS),
    localparam int IDX_W      = $clog2(INDEX_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 inverse,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [IDX_W-1:0]     out_index,
    output logic [BIT_WIDTH-1:0] twf_re,
    output logic [BIT_WIDTH-1:0] twf_im,
    output logic                 out_last,
    output logic                 busy
);

    localparam int LOG_N = GRP_BITS + POS_BITS;
    localparam int AW    = LOG_N - 1;
    localparam int QTR   = N_POINT / 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INDEX_WIDTH - 1);

    logic en;
    assign en = !out_valid || out_ready;

    // S0: frame counter
    logic [IDX_W-1:0] idx0;
    logic             v0;
    logic             inv_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx0  <= '0;
            v0    <= 1'b0;
            busy  <= 1'b0;
            inv_q <= 1'b0;
        end else if (start && !busy) begin
            idx0  <= '0;
            v0    <= 1'b1;
            busy  <= 1'b1;
            inv_q <= inverse;
        end else begin
            if (en && v0) begin
                if (idx0 == LAST_IDX) v0 <= 1'b0;
                else                  idx0 <= idx0 + IDX_W'(1);
            end
            if (out_valid && out_ready && out_last) busy <= 1'b0;
        end
    end

    // Exponent e = bitrev(grp) * pos, truncated to LOG_N bits (mod N_POINT).
    logic [GRP_BITS-1:0] grp;
    logic [GRP_BITS-1:0] grp_rev;
    logic [POS_BITS-1:0] pos;
    logic [LOG_N-1:0]    expo;
    logic [LOG_N-3:0]    rem;

    assign grp     = idx0[LOG_N-1:POS_BITS];
    assign pos     = idx0[POS_BITS-1:0];
    assign grp_rev = GRP_BITS'(bitrev(8'(grp), GRP_BITS));
    assign expo    = {{POS_BITS{1'b0}}, grp_rev} * {{GRP_BITS{1'b0}}, pos};
    assign rem     = expo[LOG_N-3:0];

    // S1: quadrant and ROM addresses for cos (r) and sin (N/4 - r)
    quad_t            quad1;
    logic [AW-1:0]    addr_c1;
    logic [AW-1:0]    addr_s1;
    logic [IDX_W-1:0] idx1;
    logic             last1;
    logic             v1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            quad1   <= Q0;
            addr_c1 <= '0;
            addr_s1 <= '0;
            idx1    <= '0;
            last1   <= 1'b0;
            v1      <= 1'b0;
        end else if (en) begin
            quad1   <= quad_t'(expo[LOG_N-1:LOG_N-2]);
            addr_c1 <= {1'b0, rem};
            addr_s1 <= AW'(QTR) - {1'b0, rem};
            idx1    <= idx0;
            last1   <= v0 && (idx0 == LAST_IDX);
            v1      <= v0;
        end
    end

    logic [ROM_BITS-1:0] rom_c;
    logic [ROM_BITS-1:0] rom_s;

    twf_qrom #(
        .N_POINT (N_POINT),
        .AW      (AW)
    ) u_qrom (
        .addr_a (addr_c1),
        .addr_b (addr_s1),
        .data_a (rom_c),
        .data_b (rom_s)
    );

    // S2: quadrant fold and forward/inverse sign on the imaginary part
    logic [BIT_WIDTH-1:0] c_ext;
    logic [BIT_WIDTH-1:0] s_ext;
    logic [BIT_WIDTH-1:0] cos_v;
    logic [BIT_WIDTH-1:0] sin_v;
    logic [BIT_WIDTH-1:0] im_v;

    assign c_ext = BIT_WIDTH'(rom_c);
    assign s_ext = BIT_WIDTH'(rom_s);

    always_comb begin
        cos_v = c_ext;
        sin_v = s_ext;
        case (quad1)
            Q0: begin cos_v = c_ext;  sin_v = s_ext;  end
            Q1: begin cos_v = -s_ext; sin_v = c_ext;  end
            Q2: begin cos_v = -c_ext; sin_v = -s_ext; end
            default: begin cos_v = s_ext; sin_v = -c_ext; end
        endcase
        im_v = inv_q ? sin_v : -sin_v;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            twf_re    <= '0;
            twf_im    <= '0;
        end else if (en) begin
            out_valid <= v1;
            out_index <= idx1;
            out_last  <= last1;
            twf_re    <= cos_v;
            twf_im    <= im_v;
        end
    end

endmodule
